// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input controller: register offsets, CTRL bit
// positions and edge-mode encodings.
package gpio_pkg;
    localparam int unsigned OFF_DATA  = 0;
    localparam int unsigned OFF_CTRL  = 4;
    localparam int unsigned OFF_MASK  = 8;
    localparam int unsigned OFF_EVENT = 12;

    localparam int CTRL_READY   = 0;
    localparam int CTRL_OVR     = 1;
    localparam int CTRL_FLUSH   = 2;
    localparam int CTRL_IE      = 4;
    localparam int CTRL_MODE_LO = 8;
    localparam int CTRL_MODE_HI = 9;

    typedef enum logic [1:0] {
        EDGE_ANY     = 2'b00,
        EDGE_RISE    = 2'b01,
        EDGE_FALL    = 2'b10,
        EDGE_ANY_ALT = 2'b11
    } edge_mode_e;
endpackage

// File: rtl/gpio_in_ctrl_if.sv
// Address/direction bundle of the register bus; the shared data lines stay a
// tristate net alongside it.
interface gpio_in_ctrl_if #(
    parameter int BITS = 32
) ();
    logic [BITS-1:0] addr;
    logic            we;

    modport master (output addr, output we);
    modport slave  (input  addr, input  we);
endinterface

// File: rtl/gpio_debounce.sv
// Per-channel 2-flop synchroniser plus 3-sample debounce filter, advanced by
// an external sample tick.
module gpio_debounce #(
    parameter int CHANNELS = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                i_tick,
    input  logic [CHANNELS-1:0] i_raw,
    output logic [CHANNELS-1:0] o_deb
);
    logic [CHANNELS-1:0] r_sync1, r_sync2, r_hist1, r_hist2, r_deb;
    logic [CHANNELS-1:0] w_stable;

    // A lane is stable when the current sample matches both earlier tick samples.
    assign w_stable = ~(r_sync2 ^ r_hist1) & ~(r_sync2 ^ r_hist2);
    assign o_deb    = r_deb;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
            r_deb   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_hist1 <= r_sync2;
                r_hist2 <= r_hist1;
                r_deb   <= (r_deb & ~w_stable) | (r_sync2 & w_stable);
            end
        end
    end
endmodule

// File: rtl/gpio_in_ctrl.sv
// Debounced switch input block with edge-qualified event FIFO, memory-mapped
// on a shared tristate data bus.
module gpio_in_ctrl
    import gpio_pkg::*;
#(
    parameter int              BITS       = 32,
    parameter int              CHANNELS   = 10,
    parameter logic [BITS-1:0] BASE       = 32'hFFFF0120,
    parameter int              DEB_TICK   = 50000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [BITS-1:0]     ADDRBUS,
    inout  wire  [BITS-1:0]     DATABUS,
    input  logic                WE,
    input  logic [CHANNELS-1:0] DEVICE,
    output logic                IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DEB_TICK);

    logic [CW-1:0]       r_cnt;
    logic [CHANNELS-1:0] r_deb_d, r_mask;
    logic [AW:0]         r_wp, r_rp;
    logic                r_ovr, r_ie;
    edge_mode_e          r_mode;
    logic [BITS-1:0]     r_mem [FIFO_DEPTH];

    logic                w_tick, w_empty, w_full, w_push, w_pop, w_flush;
    logic                w_do_push, w_ovr_set, w_rd, w_wr_ctrl, w_wr_mask;
    logic                w_sel_data, w_sel_ctrl, w_sel_mask, w_sel_evt;
    logic [CHANNELS-1:0] w_deb, w_chg, w_hit;
    logic [BITS-1:0]     w_entry, w_rdata;
    logic                w_unused;

    assign w_tick = (r_cnt == CW'(DEB_TICK - 1));

    gpio_debounce #(.CHANNELS(CHANNELS)) u_deb (
        .CLK    (CLK),
        .RESET  (RESET),
        .i_tick (w_tick),
        .i_raw  (DEVICE),
        .o_deb  (w_deb)
    );

    assign w_sel_data = (ADDRBUS == BASE + BITS'(OFF_DATA));
    assign w_sel_ctrl = (ADDRBUS == BASE + BITS'(OFF_CTRL));
    assign w_sel_mask = (ADDRBUS == BASE + BITS'(OFF_MASK));
    assign w_sel_evt  = (ADDRBUS == BASE + BITS'(OFF_EVENT));
    assign w_rd       = !WE && (w_sel_data || w_sel_ctrl || w_sel_mask || w_sel_evt);
    assign w_wr_ctrl  = WE && w_sel_ctrl;
    assign w_wr_mask  = WE && w_sel_mask;
    assign w_unused   = ^DATABUS;

    always_comb begin
        w_chg = w_deb ^ r_deb_d;
        case (r_mode)
            EDGE_RISE: w_hit = w_chg & w_deb;
            EDGE_FALL: w_hit = w_chg & ~w_deb;
            default:   w_hit = w_chg;
        endcase
        w_entry = '0;
        w_entry[CHANNELS-1:0]  = w_deb;
        w_entry[CHANNELS+15:16] = w_chg;
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = |(w_hit & r_mask);
    assign w_pop   = !WE && w_sel_evt && !w_empty;
    assign w_flush = w_wr_ctrl && DATABUS[CTRL_FLUSH];
    // Flush beats a same-cycle push; a full FIFO only accepts when a pop frees a slot.
    assign w_do_push = w_push && !w_flush && (!w_full || w_pop);
    assign w_ovr_set = w_push && !w_flush && w_full && !w_pop;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt   <= '0;
            r_deb_d <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_ovr   <= 1'b0;
            r_ie    <= 1'b1;
            r_mode  <= EDGE_ANY;
            r_mask  <= '1;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_deb_d <= w_deb;
            if (w_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_do_push) r_wp <= r_wp + (AW+1)'(1);
                if (w_pop)     r_rp <= r_rp + (AW+1)'(1);
            end
            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (w_wr_ctrl && !DATABUS[CTRL_OVR])
                r_ovr <= 1'b0;
            if (w_wr_ctrl) begin
                r_ie   <= DATABUS[CTRL_IE];
                r_mode <= edge_mode_e'(DATABUS[CTRL_MODE_HI:CTRL_MODE_LO]);
            end
            if (w_wr_mask) r_mask <= DATABUS[CHANNELS-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= w_entry;
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_data) begin
            w_rdata[CHANNELS-1:0] = w_deb;
        end else if (w_sel_ctrl) begin
            w_rdata[CTRL_READY]                = !w_empty;
            w_rdata[CTRL_OVR]                  = r_ovr;
            w_rdata[CTRL_IE]                   = r_ie;
            w_rdata[CTRL_MODE_HI:CTRL_MODE_LO] = r_mode;
        end else if (w_sel_mask) begin
            w_rdata[CHANNELS-1:0] = r_mask;
        end else if (w_sel_evt && !w_empty) begin
            w_rdata = r_mem[r_rp[AW-1:0]];
        end
    end

    assign DATABUS = w_rd ? w_rdata : 'z;
    assign IRQ     = !w_empty && r_ie;
endmodule
